// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-add slice, LSB first, valid/ready in and out.
// Optional subtract mode (in_sub port) is enabled by defining SERIAL_ADD_SUB_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;

  logic             s0;
  logic             c0;
  logic             sum_bit;
  logic             c1;
  logic [WIDTH:0]   res_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  half_adder ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(s0),      .c(c0));
  half_adder ha1 (.a(s0),      .b(carry),   .s(sum_bit), .c(c1));

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at position 0.
  always_comb begin
    res_shift = {sum_bit, res};
  end

  // Operand B / initial carry selection at load time (two's-complement subtract when enabled).
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    if (in_sub) begin
      b_load     = ~in_b;
      carry_load = 1'b1;
    end else begin
      b_load     = in_b;
      carry_load = 1'b0;
    end
`else
    b_load     = in_b;
    carry_load = 1'b0;
`endif
  end

  // Sequencer FSM with registered handshake/status outputs and the serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr    <= in_a;
            b_sr    <= b_load;
            carry   <= carry_load;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          res   <= res_shift[WIDTH:1];
          carry <= c0 | c1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = ready_q & rst_n;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign out_sum   = res;
  assign out_carry = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic seen_valid;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_sum, input logic exp_carry);
    chk({tag, "_in_ready_pre"}, in_ready, 1'b1);
    accept(a, b);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_carry"}, out_carry, exp_carry);
    take();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 8'h00);
    chk("rst_out_carry", out_carry, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Basic add with explicit RUN status check
    accept(8'h0F, 8'h01);
    chk("basic_busy_run", busy, 1'b1);
    chk("basic_in_ready_run", in_ready, 1'b0);
    wait_valid(lat);
    chk("basic_latency", lat, 8);
    chk("basic_sum", out_sum, 8'h10);
    chk("basic_carry", out_carry, 1'b0);
    chk("basic_busy_done", busy, 1'b1);
    take();
    chk("basic_in_ready_after", in_ready, 1'b1);
    chk("basic_out_valid_after", out_valid, 1'b0);
    chk("basic_busy_after", busy, 1'b0);

    run_op("wrap1", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("wrap2", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_op("mix", 8'hA5, 8'h3C, 8'hE1, 1'b0);

    // Backpressure: result must hold while out_ready is low
    accept(8'h3C, 8'hC3);
    wait_valid(lat);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_hold", out_valid, 1'b1);
      chk("bp_sum_hold", out_sum, 8'hFF);
      chk("bp_carry_hold", out_carry, 1'b0);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    take();
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("bp_out_valid_after", out_valid, 1'b0);

    // Ignored inputs during RUN/DONE; held in_valid accepted only after return to IDLE
    accept(8'h12, 8'h34);
    in_a     = 8'hAA;
    in_b     = 8'h11;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("ign_in_ready_run", in_ready, 1'b0);
    wait_valid(lat);
    chk("ign_latency", lat, 7);
    chk("ign_sum", out_sum, 8'h46);
    chk("ign_carry", out_carry, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ign_idle_in_ready", in_ready, 1'b1);
    chk("ign_idle_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ign_second_accepted", busy, 1'b1);
    wait_valid(lat);
    chk("ign2_latency", lat, 8);
    chk("ign2_sum", out_sum, 8'hBB);
    chk("ign2_carry", out_carry, 1'b0);
    take();

    // Reset in the middle of an operation
    accept(8'h55, 8'h2A);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", out_sum, 8'h00);
    chk("mid_rst_carry", out_carry, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid;
    end
    chk("post_rst_no_valid", seen_valid, 1'b0);
    run_op("post_rst", 8'h01, 8'h01, 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    in_sub = 1'b1;
    run_op("sub1", 8'h05, 8'h07, 8'hFE, 1'b0);
    run_op("sub2", 8'h07, 8'h05, 8'h02, 1'b1);
    in_sub = 1'b0;
    run_op("sub_off", 8'h07, 8'h05, 8'h0C, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
